// File: rtl/alt_mem_ddrx_st_mm_pkg.sv
// Shared types and sizing helpers for the ST-to-MM converter.
package alt_mem_ddrx_st_mm_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  function automatic int max_burst(input int size_width);
    return (1 << size_width) - 1;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/alt_mem_ddrx_st_mm_fifo.sv
// Show-ahead FIFO: head word visible while not empty, push-to-visible one cycle.
// Pushes when full and pops when empty are dropped.
module alt_mem_ddrx_st_mm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alt_mem_ddrx_st_mm_converter.sv
// Avalon-ST command/write/read triple to Avalon-MM burst master; reads gated by buffer credits.
// ALT_MEM_DDRX_ST_MM_RD_ERR_EN: keep avm_response_err per read beat and report it on itf_rd_data_error.
module alt_mem_ddrx_st_mm_converter #(
  parameter int AVL_SIZE_WIDTH = 3,
  parameter int AVL_ADDR_WIDTH = 25,
  parameter int AVL_DATA_WIDTH = 32,
  parameter int LOCAL_ID_WIDTH = 8,
  parameter int MAX_RD_CMD     = 4,
  parameter int RDATA_DEPTH    = 16
) (
  input  logic                        ctl_clk,
  input  logic                        ctl_reset,
  input  logic                        itf_cmd_valid,
  output logic                        itf_cmd_ready,
  input  logic                        itf_cmd,
  input  logic [AVL_ADDR_WIDTH-1:0]   itf_cmd_address,
  input  logic [AVL_SIZE_WIDTH-1:0]   itf_cmd_burstlen,
  input  logic [LOCAL_ID_WIDTH-1:0]   itf_cmd_id,
  input  logic                        itf_cmd_priority,
  input  logic                        itf_cmd_autopercharge,
  input  logic                        itf_cmd_multicast,
  input  logic                        itf_wr_data_valid,
  output logic                        itf_wr_data_ready,
  input  logic [AVL_DATA_WIDTH-1:0]   itf_wr_data,
  input  logic [AVL_DATA_WIDTH/8-1:0] itf_wr_data_byte_en,
  input  logic                        itf_wr_data_begin,
  input  logic                        itf_wr_data_last,
  input  logic [LOCAL_ID_WIDTH-1:0]   itf_wr_data_id,
  input  logic                        itf_rd_data_ready,
  output logic                        itf_rd_data_valid,
  output logic [AVL_DATA_WIDTH-1:0]   itf_rd_data,
  output logic                        itf_rd_data_error,
  output logic                        itf_rd_data_begin,
  output logic                        itf_rd_data_last,
  output logic [LOCAL_ID_WIDTH-1:0]   itf_rd_data_id,
  input  logic                        avm_waitrequest,
  output logic                        avm_read,
  output logic                        avm_write,
  output logic                        avm_burstbegin,
  output logic [AVL_ADDR_WIDTH-1:0]   avm_address,
  output logic [AVL_SIZE_WIDTH-1:0]   avm_burstcount,
  output logic [AVL_DATA_WIDTH-1:0]   avm_writedata,
  output logic [AVL_DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                        avm_readdatavalid,
  input  logic [AVL_DATA_WIDTH-1:0]   avm_readdata,
  input  logic                        avm_response_err
);
  import alt_mem_ddrx_st_mm_pkg::*;

  localparam int CW = credit_width(RDATA_DEPTH);
  localparam int TW = LOCAL_ID_WIDTH + AVL_SIZE_WIDTH;
`ifdef ALT_MEM_DDRX_ST_MM_RD_ERR_EN
  localparam int FW = AVL_DATA_WIDTH + 1;
`else
  localparam int FW = AVL_DATA_WIDTH;
`endif

  state_t                      state, next_state;
  logic [AVL_ADDR_WIDTH-1:0]   cmd_addr;
  logic [AVL_SIZE_WIDTH-1:0]   cmd_len, beat_cnt, out_cnt, req_len, trk_len;
  logic [LOCAL_ID_WIDTH-1:0]   cmd_id, trk_id;
  logic [CW-1:0]               credits;
  logic [TW-1:0]               trk_head;
  logic [FW-1:0]               fifo_in, fifo_out;
  logic                        accept, wr_beat, rd_issue, rd_pop, rd_last, credit_ok;
  logic                        trk_full, trk_empty, fifo_full, fifo_empty;

  assign req_len   = (itf_cmd_burstlen == '0) ? AVL_SIZE_WIDTH'(1) : itf_cmd_burstlen;
  assign accept    = itf_cmd_valid & itf_cmd_ready;
  assign wr_beat   = avm_write & ~avm_waitrequest;
  assign rd_issue  = avm_read & ~avm_waitrequest;
  assign rd_pop    = itf_rd_data_valid & itf_rd_data_ready;
  assign credit_ok = (credits >= CW'(cmd_len));

  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = itf_cmd ? WR : RD;
      WR:      if (wr_beat && beat_cnt == AVL_SIZE_WIDTH'(1)) next_state = IDLE;
      RD:      if (rd_issue) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    itf_cmd_ready     = 1'b0;
    itf_wr_data_ready = 1'b0;
    avm_write         = 1'b0;
    avm_read          = 1'b0;
    avm_burstbegin    = 1'b0;
    avm_writedata     = '0;
    avm_byteenable    = '0;
    case (state)
      IDLE: itf_cmd_ready = ~trk_full & ~ctl_reset;
      WR: begin
        avm_write         = itf_wr_data_valid;
        itf_wr_data_ready = ~avm_waitrequest;
        // beat_cnt still equals the burst length until the first beat is taken
        avm_burstbegin    = itf_wr_data_valid & (beat_cnt == cmd_len);
        avm_writedata     = itf_wr_data;
        avm_byteenable    = itf_wr_data_byte_en;
      end
      RD: begin
        avm_read       = credit_ok;
        avm_burstbegin = credit_ok;
      end
      default: ;
    endcase
  end

  assign avm_address    = cmd_addr;
  assign avm_burstcount = cmd_len;

  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      cmd_addr <= '0;
      cmd_len  <= '0;
      cmd_id   <= '0;
      beat_cnt <= '0;
      out_cnt  <= '0;
      credits  <= CW'(RDATA_DEPTH);
    end else begin
      if (accept) begin
        cmd_addr <= itf_cmd_address;
        cmd_len  <= req_len;
        cmd_id   <= itf_cmd_id;
        beat_cnt <= req_len;
      end else if (wr_beat) begin
        beat_cnt <= beat_cnt - AVL_SIZE_WIDTH'(1);
      end
      if (rd_pop) out_cnt <= rd_last ? '0 : out_cnt + AVL_SIZE_WIDTH'(1);
      // a whole burst of buffer space is reserved at issue, returned one beat at a time
      credits <= credits - (rd_issue ? CW'(cmd_len) : '0) + (rd_pop ? CW'(1) : '0);
    end
  end

  alt_mem_ddrx_st_mm_fifo #(.WIDTH(TW), .DEPTH(MAX_RD_CMD)) u_tracker (
    .clk(ctl_clk), .rst(ctl_reset),
    .push(rd_issue), .push_data({cmd_id, cmd_len}),
    .pop(rd_pop & rd_last), .pop_data(trk_head),
    .full(trk_full), .empty(trk_empty)
  );

  alt_mem_ddrx_st_mm_fifo #(.WIDTH(FW), .DEPTH(RDATA_DEPTH)) u_rdata (
    .clk(ctl_clk), .rst(ctl_reset),
    .push(avm_readdatavalid), .push_data(fifo_in),
    .pop(rd_pop), .pop_data(fifo_out),
    .full(fifo_full), .empty(fifo_empty)
  );

  assign {trk_id, trk_len}  = trk_head;
  assign rd_last            = (out_cnt + AVL_SIZE_WIDTH'(1) == trk_len);
  assign itf_rd_data_valid  = ~fifo_empty & ~trk_empty;
  assign itf_rd_data        = itf_rd_data_valid ? fifo_out[AVL_DATA_WIDTH-1:0] : '0;
  assign itf_rd_data_begin  = itf_rd_data_valid & (out_cnt == '0);
  assign itf_rd_data_last   = itf_rd_data_valid & rd_last;
  assign itf_rd_data_id     = itf_rd_data_valid ? trk_id : '0;

`ifdef ALT_MEM_DDRX_ST_MM_RD_ERR_EN
  assign fifo_in           = {avm_response_err, avm_readdata};
  assign itf_rd_data_error = itf_rd_data_valid & fifo_out[FW-1];
`else
  logic unused_err;
  assign fifo_in           = avm_readdata;
  assign itf_rd_data_error = 1'b0;
  assign unused_err        = avm_response_err;
`endif

  logic unused_inputs;
  assign unused_inputs = &{1'b0, itf_cmd_priority, itf_cmd_autopercharge, itf_cmd_multicast,
                           itf_wr_data_begin, itf_wr_data_last, itf_wr_data_id, fifo_full};

endmodule

// File: tb/tb_alt_mem_ddrx_st_mm_converter.sv
// Directed bench for alt_mem_ddrx_st_mm_converter; honours ALT_MEM_DDRX_ST_MM_RD_ERR_EN.
module tb_alt_mem_ddrx_st_mm_converter;
  import alt_mem_ddrx_st_mm_pkg::*;

`ifdef ALT_MEM_DDRX_ST_MM_RD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd;
  logic [24:0] cmd_address;
  logic [2:0]  cmd_burstlen;
  logic [7:0]  cmd_id;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_ready, rd_valid, rd_error, rd_begin, rd_last;
  logic [31:0] rd_data;
  logic [7:0]  rd_id;
  logic        waitreq, avm_read, avm_write, avm_burstbegin;
  logic [24:0] avm_address;
  logic [2:0]  avm_burstcount;
  logic [31:0] avm_writedata, avm_readdata;
  logic [3:0]  avm_byteenable;
  logic        rdv, rerr;

  int total = 0;
  int bad   = 0;
  int wr_hs = 0;
  int bb_hs = 0;
  int rd_hs = 0;
  int base;

  always #5 clk = ~clk;

  alt_mem_ddrx_st_mm_converter dut (
    .ctl_clk(clk), .ctl_reset(rst),
    .itf_cmd_valid(cmd_valid), .itf_cmd_ready(cmd_ready), .itf_cmd(cmd),
    .itf_cmd_address(cmd_address), .itf_cmd_burstlen(cmd_burstlen), .itf_cmd_id(cmd_id),
    .itf_cmd_priority(1'b0), .itf_cmd_autopercharge(1'b0), .itf_cmd_multicast(1'b0),
    .itf_wr_data_valid(wr_valid), .itf_wr_data_ready(wr_ready),
    .itf_wr_data(wr_data), .itf_wr_data_byte_en(wr_be),
    .itf_wr_data_begin(1'b0), .itf_wr_data_last(1'b0), .itf_wr_data_id(8'h00),
    .itf_rd_data_ready(rd_ready), .itf_rd_data_valid(rd_valid), .itf_rd_data(rd_data),
    .itf_rd_data_error(rd_error), .itf_rd_data_begin(rd_begin), .itf_rd_data_last(rd_last),
    .itf_rd_data_id(rd_id),
    .avm_waitrequest(waitreq), .avm_read(avm_read), .avm_write(avm_write),
    .avm_burstbegin(avm_burstbegin), .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdatavalid(rdv), .avm_readdata(avm_readdata), .avm_response_err(rerr)
  );

  // handshake counters observed at the clock edge
  always @(posedge clk) begin
    if (!rst) begin
      if (avm_write && !waitreq) wr_hs <= wr_hs + 1;
      if (avm_write && !waitreq && avm_burstbegin) bb_hs <= bb_hs + 1;
      if (avm_read && !waitreq) rd_hs <= rd_hs + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_cmd(input logic wr, input logic [24:0] a, input logic [2:0] len,
                            input logic [7:0] id);
    cmd_valid = 1'b1; cmd = wr; cmd_address = a; cmd_burstlen = len; cmd_id = id;
    #1;
    check("cmd_ready_at_accept", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd = 0; cmd_address = 0; cmd_burstlen = 0; cmd_id = 0;
    wr_valid = 0; wr_data = 0; wr_be = 0; rd_ready = 0; waitreq = 0;
    rdv = 0; avm_readdata = 0; rerr = 0;
    tick(); tick();
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_avm_write", avm_write, 1'b0);
    check("reset_avm_read", avm_read, 1'b0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_burstcount", avm_burstcount, 3'd0);
    rst = 1'b0;
    #1;
    check("post_reset_cmd_ready", cmd_ready, 1'b1);

    // write burst of 4 with waitrequest stalling beat 2 for two cycles
    accept_cmd(1'b1, 25'h100, 3'd4, 8'h00);
    wr_valid = 1; wr_data = 32'hA0; wr_be = 4'hF; #1;
    check("wr_b1_write", avm_write, 1'b1);
    check("wr_b1_bb", avm_burstbegin, 1'b1);
    check("wr_addr", avm_address, 25'h100);
    check("wr_bc", avm_burstcount, 3'd4);
    check("wr_b1_data", avm_writedata, 32'hA0);
    check("wr_b1_ready", wr_ready, 1'b1);
    tick();
    wr_data = 32'hA1; waitreq = 1; #1;
    check("wr_b2_bb", avm_burstbegin, 1'b0);
    check("wr_b2_stall_ready", wr_ready, 1'b0);
    tick(); tick();
    check("wr_addr_held", avm_address, 25'h100);
    check("wr_bc_held", avm_burstcount, 3'd4);
    waitreq = 0; #1;
    check("wr_b2_data", avm_writedata, 32'hA1);
    tick();
    wr_data = 32'hA2; tick();
    wr_data = 32'hA3; #1;
    check("wr_b4_cmd_ready", cmd_ready, 1'b0);
    tick();
    wr_valid = 0; #1;
    check("wr_done_cmd_ready", cmd_ready, 1'b1);
    check("wr_done_write", avm_write, 1'b0);
    check("wr_beats", wr_hs, 4);
    check("wr_burstbegins", bb_hs, 1);

    // read burst of 4, id 0x5A
    base = rd_hs;
    accept_cmd(1'b0, 25'h200, 3'd4, 8'h5A);
    check("rd_read", avm_read, 1'b1);
    check("rd_bb", avm_burstbegin, 1'b1);
    check("rd_bc", avm_burstcount, 3'd4);
    tick();
    check("rd_read_dropped", avm_read, 1'b0);
    check("rd_issued_once", rd_hs - base, 1);
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      rdv = 1; avm_readdata = 32'hD0 + i; #1;
      if (i == 0) check("rd_not_yet_valid", rd_valid, 1'b0);
      tick();
      check("rd_valid", rd_valid, 1'b1);
      check("rd_data", rd_data, 32'hD0 + i);
      check("rd_begin", rd_begin, i == 0);
      check("rd_last", rd_last, i == 3);
      check("rd_id", rd_id, 8'h5A);
    end
    rdv = 0;
    tick();
    check("rd_drained", rd_valid, 1'b0);

    // credit limit: three bursts of 7 against a 16-word buffer with the sink stalled
    rd_ready = 0;
    accept_cmd(1'b0, 25'h300, 3'd7, 8'h11);
    check("cr_read1", avm_read, 1'b1);
    tick();
    accept_cmd(1'b0, 25'h310, 3'd7, 8'h22);
    check("cr_read2", avm_read, 1'b1);
    tick();
    accept_cmd(1'b0, 25'h320, 3'd7, 8'h33);
    check("cr_read3_blocked", avm_read, 1'b0);
    for (int i = 0; i < 14; i++) begin
      rdv = 1; avm_readdata = 32'h700 + i;
      tick();
    end
    rdv = 0; #1;
    check("cr_still_blocked", avm_read, 1'b0);
    rd_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    check("cr_six_credits", avm_read, 1'b0);
    tick();
    check("cr_seven_credits", avm_read, 1'b1);
    check("cr_head_data", rd_data, 32'h705);
    check("cr_head_id", rd_id, 8'h11);
    tick();
    check("cr_b1_last", rd_last, 1'b1);
    check("cr_b1_last_id", rd_id, 8'h11);
    tick();
    check("cr_b2_begin", rd_begin, 1'b1);
    check("cr_b2_id", rd_id, 8'h22);
    check("cr_b2_data", rd_data, 32'h707);
    for (int k = 0; k < 7; k++) tick();
    check("cr_empty", rd_valid, 1'b0);
    check("cr_idle", cmd_ready, 1'b1);
    for (int i = 0; i < 7; i++) begin
      rdv = 1; avm_readdata = 32'h780 + i;
      tick();
    end
    rdv = 0; #1;
    check("cr_b3_last", rd_last, 1'b1);
    check("cr_b3_id", rd_id, 8'h33);
    tick();
    check("cr_b3_drained", rd_valid, 1'b0);

    // tracker depth: four single-beat reads outstanding
    for (int k = 0; k < 4; k++) begin
      accept_cmd(1'b0, 25'h400 + k, 3'd1, 8'h40 + k);
      tick();
    end
    check("trk_full_ready", cmd_ready, 1'b0);
    tick(); tick();
    check("trk_full_hold", cmd_ready, 1'b0);
    rdv = 1; avm_readdata = 32'hB0;
    tick();
    rdv = 0; #1;
    check("trk_beat_id", rd_id, 8'h40);
    check("trk_beat_last", rd_last, 1'b1);
    check("trk_before_pop", cmd_ready, 1'b0);
    tick();
    check("trk_after_pop", cmd_ready, 1'b1);
    for (int j = 1; j < 4; j++) begin
      rdv = 1; avm_readdata = 32'hB0 + j;
      tick();
      check("trk_id_seq", rd_id, 8'h40 + j);
    end
    rdv = 0;
    tick();
    check("trk_drained", rd_valid, 1'b0);

    // reset in the middle of a 4-beat write
    accept_cmd(1'b1, 25'h500, 3'd4, 8'h00);
    wr_valid = 1; wr_data = 32'hC0; tick();
    wr_data = 32'hC1; tick();
    rst = 1; #1;
    check("mid_rst_write", avm_write, 1'b0);
    check("mid_rst_wr_ready", wr_ready, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    tick();
    rst = 0; wr_valid = 0; #1;
    check("after_rst_cmd_ready", cmd_ready, 1'b1);
    check("after_rst_write", avm_write, 1'b0);
    base = rd_hs;
    accept_cmd(1'b0, 25'h600, 3'd7, 8'h77);
    check("after_rst_read1", avm_read, 1'b1);
    tick();
    accept_cmd(1'b0, 25'h610, 3'd7, 8'h78);
    check("after_rst_read2", avm_read, 1'b1);
    tick();
    accept_cmd(1'b0, 25'h620, 3'd7, 8'h79);
    check("after_rst_read3_blocked", avm_read, 1'b0);
    for (int i = 0; i < 14; i++) begin
      rdv = 1; avm_readdata = 32'h800 + i;
      tick();
      if (i == 0) begin
        check("after_rst_begin", rd_begin, 1'b1);
        check("after_rst_id", rd_id, 8'h77);
      end
    end
    rdv = 0; #1;
    check("after_rst_issued", rd_hs - base, 3);
    for (int i = 0; i < 7; i++) begin
      rdv = 1; avm_readdata = 32'h900 + i;
      tick();
    end
    rdv = 0;
    tick(); tick();
    check("after_rst_drained", rd_valid, 1'b0);
    check("after_rst_idle", cmd_ready, 1'b1);

    // read error reported on beat 2 only
    accept_cmd(1'b0, 25'h700, 3'd4, 8'h66);
    tick();
    for (int i = 0; i < 4; i++) begin
      rdv = 1; rerr = (i == 1); avm_readdata = 32'hE0 + i;
      tick();
      check("err_data", rd_data, 32'hE0 + i);
      check("err_flag", rd_error, ERR_EN && (i == 1));
    end
    rdv = 0; rerr = 0;
    tick();
    check("err_drained", rd_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alt_mem_ddrx_st_mm_converter.md
# alt_mem_ddrx_st_mm_converter

Converts the controller-side Avalon-ST triple (single command channel, multi-beat write data channel, read data channel) back into an Avalon-MM burst master. Sits wherever an ST-native requester must drive an MM slave, e.g. test/loopback paths and bridges onto MM memory models. It consumes the stream that the MM-to-ST converter produces, issues Avalon bursts, and re-frames returned read data with begin/last/id. Read data is buffered with credit-based flow control because `avm_readdatavalid` cannot be back-pressured.

## Interface
- AVL_SIZE_WIDTH, 3, burst length width; max burst = 2^AVL_SIZE_WIDTH-1
- AVL_ADDR_WIDTH, 25, word address width
- AVL_DATA_WIDTH, 32, data width; BE width = AVL_DATA_WIDTH/8
- LOCAL_ID_WIDTH, 8, command/read id width
- MAX_RD_CMD, 4, outstanding read commands (tracker depth, power of 2)
- RDATA_DEPTH, 16, read data buffer words; must be ≥ max burst
- ctl_clk  in  1  controller clock
- ctl_reset  in  1  asynchronous, active-high reset
- itf_cmd_valid / itf_cmd_ready  in/out  1  command handshake
- itf_cmd  in  1  1 = write, 0 = read
- itf_cmd_address  in  AVL_ADDR_WIDTH  burst start address
- itf_cmd_burstlen  in  AVL_SIZE_WIDTH  beats; 0 treated as 1
- itf_cmd_id  in  LOCAL_ID_WIDTH  read tag, returned on read data
- itf_cmd_priority, itf_cmd_autopercharge, itf_cmd_multicast  in  1  sampled, not forwarded
- itf_wr_data_valid / itf_wr_data_ready  in/out  1  write data handshake
- itf_wr_data  in  AVL_DATA_WIDTH; itf_wr_data_byte_en  in  AVL_DATA_WIDTH/8
- itf_wr_data_begin, itf_wr_data_last, itf_wr_data_id  in  ignored; beat count taken from command
- itf_rd_data_ready  in  1; itf_rd_data_valid  out  1
- itf_rd_data  out  AVL_DATA_WIDTH; itf_rd_data_error, itf_rd_data_begin, itf_rd_data_last  out  1; itf_rd_data_id  out  LOCAL_ID_WIDTH
- avm_waitrequest  in  1; avm_read, avm_write, avm_burstbegin  out  1
- avm_address  out  AVL_ADDR_WIDTH; avm_burstcount  out  AVL_SIZE_WIDTH
- avm_writedata  out  AVL_DATA_WIDTH; avm_byteenable  out  AVL_DATA_WIDTH/8
- avm_readdatavalid  in  1; avm_readdata  in  AVL_DATA_WIDTH; avm_response_err  in  1

## Operation
- FSM states: IDLE, WR, RD.
- itf_cmd_ready = IDLE & ~tracker_full & ~ctl_reset.
- On accept, register address, burstlen (0→1), id, type. Go to WR or RD.
- WR: avm_write = itf_wr_data_valid. itf_wr_data_ready = ~avm_waitrequest. Data and byte enables pass combinationally. avm_burstbegin only on the first beat. Beat counter loads burstlen and decrements per accepted beat. Accepting the beat with count==1 → IDLE.
- RD: avm_read = (credits ≥ burstlen). When avm_read & ~avm_waitrequest:
  - push {id, burstlen} to the tracker;
  - credits -= burstlen;
  - → IDLE.
- avm_burstbegin is also asserted with avm_read.
- Credits: reset value RDATA_DEPTH, width clog2(RDATA_DEPTH+1). +1 per itf_rd_data beat popped. Simultaneous issue and pop apply net. Credits never exceed RDATA_DEPTH.
- Every avm_readdatavalid beat writes {data, err} into the rdata FIFO. The FIFO cannot overflow, by construction of the credit rule.
- Output framing:
  - itf_rd_data_valid = FIFO not empty.
  - Output beat counter versus tracker-head burstlen drives begin (first beat) and last (final beat).
  - itf_rd_data_id = tracker-head id.
  - The tracker pops on the last-beat handshake.
- Reset (any time, including mid-burst):
  - State returns to IDLE; FIFOs empty; credits = RDATA_DEPTH; counters 0.
  - All outputs are 0 while reset is asserted, including itf_cmd_ready.

## Timing
- Command accept at cycle N → avm_read/avm_write eligible at N+1.
- Write data has zero-latency pass-through; 1 beat/cycle when waitrequest is low.
- avm_readdatavalid at cycle M → itf_rd_data_valid at M+1 (registered FIFO, show-ahead). Sustained 1 beat/cycle.
- Back-to-back commands: minimum 1 idle cycle (IDLE) between bursts.

## Configuration
- ALT_MEM_DDRX_ST_MM_RD_ERR_EN defined: avm_response_err is stored per beat, and itf_rd_data_error reflects that beat.
- Not defined: the error bit is not stored, FIFO width is data only, and itf_rd_data_error is tied 0.

## Structure
- Package alt_mem_ddrx_st_mm_pkg holds:
  - state enum {IDLE, WR, RD};
  - MAX_BURST constant function;
  - credit width function.
- Sub-module alt_mem_ddrx_st_mm_fifo: synchronous show-ahead FIFO with parameters width/depth and async active-high reset, providing full/empty. It is instantiated twice: the read tracker and the rdata buffer.

## Test plan
- Write, burstlen 4, address 0x100, waitrequest high on beat 2 for 2 cycles → exactly 4 avm_write beats, address 0x100 and burstcount 4 held, burstbegin on beat 1 only, itf_cmd_ready high again the cycle after beat 4.
- Read, burstlen 4, id 0x5A, slave returns D0..D3 → one avm_read cycle with burstcount 4; itf_rd_data D0..D3 each one cycle after readdatavalid, begin on D0, last on D3, id 0x5A.
- RDATA_DEPTH=16, itf_rd_data_ready=0, three reads of burstlen 7 → first two issue; third holds avm_read=0 (credits 2). It issues once credits reach 7 after the sink drains.
- MAX_RD_CMD=4, four burstlen-1 reads with no return → itf_cmd_ready drops after the 4th accept and reasserts after the first returned beat is popped.
- Reset asserted after beat 2 of a 4-beat write → avm_write 0 immediately; after release: IDLE, itf_cmd_ready=1, credits 16, a new read issues normally.
- avm_response_err=1 on beat 2 of a 4-beat read → itf_rd_data_error=1 on beat 2 only with ALT_MEM_DDRX_ST_MM_RD_ERR_EN; 0 on all beats without it.
